uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Message-atomic round-robin arbiter that shares one `simple_uart_tx` transmit FIFO among up to 8 byte-stream requesters (console, debug trace, telemetry, ...). It sits between the requesters and the UART's `fifo_in`/`fifo_write`/`fifo_full` port. Once a requester is granted, it owns the FIFO until its last-byte marker is accepted or its idle timeout expires, so messages never interleave on the wire.

## Interface
- `NREQ`, 4, number of requesters, legal 2..8
- `TIMEOUT`, 1023, granted-but-idle cycles before forced release; 0 disables timeout
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `req_data`  in  NREQ*8  byte from requester i in bits [8i+7:8i]
- `req_valid`  in  NREQ  requester i has a byte
- `req_last`  in  NREQ  byte from requester i ends its message
- `req_ready`  out  NREQ  byte from requester i accepted this cycle when valid
- `req_abort`  out  NREQ  one-cycle pulse: requester i's grant revoked by timeout
- `fifo_in`  out  8  byte to UART TX FIFO
- `fifo_write`  out  1  write strobe to UART TX FIFO
- `fifo_full`  in  1  UART TX FIFO full
- `busy`  out  1  a grant is held
- `grant_id`  out  3  index of current or most recent grantee

## Operation
- States: IDLE, SEND.
- IDLE: if any `req_valid` is high, pick the first valid index searching upward from `rr_ptr` with wrap-around; register `grant_id`, go to SEND. No bytes move in IDLE.
- SEND: `req_ready[g] = ~fifo_full`; all other `req_ready` bits 0. `fifo_write = req_valid[g] & ~fifo_full`; `fifo_in = req_data[g]` in SEND, 8'h00 in IDLE.
- Byte with `req_last[g]` accepted: go to IDLE, `rr_ptr <= (g+1) mod NREQ`.
- Idle counter: cleared on grant and on every accepted byte. Increments in SEND when `req_valid[g]` is 0. Cycles stalled by `fifo_full` do not count. When the counter reaches TIMEOUT (TIMEOUT≠0), pulse `req_abort[g]`, go to IDLE, and advance `rr_ptr` as for a normal end.
- `req_last` without `req_valid` is ignored. Valid on a non-granted requester only waits; it is never dropped.
- Counter width: `$clog2(TIMEOUT+1)`, minimum 1 bit. No wrap is possible because release occurs at TIMEOUT.

## Timing
- Reset (async assert, sync-safe deassert externally): state IDLE, `rr_ptr` 0, `grant_id` 0, `busy` 0, `req_ready` 0, `req_abort` 0, `fifo_write` 0, `fifo_in` 8'h00, idle counter 0. Reset during SEND drops the grant immediately; any partial message is abandoned.
- Grant latency: `req_valid` seen in IDLE at cycle N gives `busy` = 1 at N+1. The first byte can be written at N+1.
- Throughput: 1 byte/cycle while `~fifo_full`. `req_ready`/`fifo_write` are combinational from registered state, `req_valid` and `fifo_full`.
- Message gap: last byte accepted at cycle M, IDLE at M+1, next grant at M+2. Exactly one dead cycle, even when the same requester is the only one requesting.
- Last byte accepted while `fifo_full` is asserted: impossible, because acceptance requires `~fifo_full`.
- Timeout and byte acceptance in the same cycle: acceptance wins and clears the counter.
- `req_abort` is asserted in the cycle the state leaves SEND.

## Structure
- Package `uart_arb_pkg`: state encoding (IDLE=1'b0, SEND=1'b1) and the `grant_id` width constant (3).
- Sub-module `rr_pick`: combinational round-robin priority picker with inputs `req[NREQ-1:0]` and `ptr`, and outputs `found` and `idx`. The top level holds the FSM, pointer, timeout counter and muxing.
- Expected size: about 150-250 lines.

## Test plan
- Single requester 1 sends 3 bytes 8'h41, 8'h42, 8'h43 (last on 8'h43), FIFO never full. Expect `busy` 1 cycle after valid, 3 consecutive `fifo_write` pulses with those bytes, `busy` low after, `rr_ptr`=2.
- Requesters 0 and 2 both present 2-byte messages from reset. Expect the 0 message fully, one gap cycle, then the 2 message, with no interleaving. Repeat so that 2 is served first when `rr_ptr`=1.
- Hold `fifo_full` high for 10 cycles mid-message with TIMEOUT=4. Expect no write, no abort, and `req_ready` low; resume on release.
- Granted requester drops valid with TIMEOUT=4. Expect `req_abort[g]` pulse exactly 4 cycles after the last accepted byte, IDLE next cycle, and a waiting requester granted after that.
- Assert `rst` mid-message. Expect immediate `fifo_write`=0, `busy`=0, `fifo_in`=8'h00, and a fresh arbitration from index 0 after deassert.
- NREQ=8, all valid continuously with 1-byte messages. Expect grants in order 0,1,...,7,0, each taking 2 cycles.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and grant index width for the UART TX arbiter
package uart_arb_pkg;
  localparam int GID_W = 3;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GID_W-1:0] ptr,
  output logic             found,
  output logic [GID_W-1:0] idx
);
  logic [NREQ-1:0] rot;
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    found = |req;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) idx = GID_W'((int'(ptr) + k) % NREQ);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-atomic round-robin sharing of one UART TX FIFO among NREQ byte streams
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   req_abort,
  output logic [7:0]        fifo_in,
  output logic              fifo_write,
  input  logic              fifo_full,
  output logic              busy,
  output logic [GID_W-1:0]  grant_id
);
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  state_t           state;
  logic [GID_W-1:0] rr_ptr, pick_idx, nxt_ptr;
  logic [CW-1:0]    cnt;
  logic [NREQ-1:0]  gmask;
  logic             found, send, g_valid, g_last, accept, tmo;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .found(found),
    .idx  (pick_idx)
  );
  assign send       = state == SEND;
  assign gmask      = NREQ'(1) << grant_id;
  assign g_valid    = |(req_valid & gmask);
  assign g_last     = |(req_last & gmask);
  assign accept     = send & g_valid & ~fifo_full;
  // the idle cycle that would bring the counter to TIMEOUT is the abort cycle itself
  assign tmo        = (TIMEOUT != 0) & send & ~g_valid & ~fifo_full & (cnt == CW'(TO_M1));
  assign nxt_ptr    = (grant_id == GID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign req_ready  = (send & ~fifo_full) ? gmask : '0;
  assign req_abort  = tmo ? gmask : '0;
  assign fifo_write = accept;
  assign fifo_in    = send ? 8'(req_data >> {grant_id, 3'b000}) : 8'h00;
  assign busy       = send;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      cnt      <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (found) begin
        state    <= SEND;
        grant_id <= pick_idx;
      end
    end else if ((accept & g_last) | tmo) begin
      state  <= IDLE;
      rr_ptr <= nxt_ptr;
    end else if (accept) begin
      cnt <= '0;
    end else if (~g_valid & ~fifo_full) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table on a 4-requester arbiter plus an 8-requester rotation run
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_data = '0;
  logic [3:0]  req_valid = '0, req_last = '0;
  logic [3:0]  req_ready, req_abort;
  logic [7:0]  fifo_in;
  logic        fifo_write, busy;
  logic        fifo_full = 1'b0;
  logic [2:0]  grant_id;
  logic        rst_b = 1'b1;
  logic [63:0] data_b;
  logic [7:0]  ready_b, abort_b, fin_b;
  logic        write_b, busy_b;
  logic [2:0]  gid_b;
  int          n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .req_abort(req_abort), .fifo_in(fifo_in), .fifo_write(fifo_write),
    .fifo_full(fifo_full), .busy(busy), .grant_id(grant_id)
  );
  uart_tx_arbiter #(.NREQ(8), .TIMEOUT(1023)) dut8 (
    .clk(clk), .rst(rst_b), .req_data(data_b), .req_valid(8'hFF), .req_last(8'hFF),
    .req_ready(ready_b), .req_abort(abort_b), .fifo_in(fin_b), .fifo_write(write_b),
    .fifo_full(1'b0), .busy(busy_b), .grant_id(gid_b)
  );
  typedef struct {
    logic        r;
    logic [3:0]  v, l;
    logic [31:0] d;
    logic        f;
    logic        b;
    logic [2:0]  g;
    logic [3:0]  ry, ab;
    logic        w;
    logic [7:0]  i;
  } vec_t;
  vec_t vecs[$];
  function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic f, input logic b,
                              input logic [2:0] g, input logic [3:0] ry, input logic [3:0] ab,
                              input logic w, input logic [7:0] i);
    vecs.push_back('{r, v, l, d, f, b, g, ry, ab, w, i});
  endfunction
  initial begin
    logic [22:0] act, exp;
    for (int k = 0; k < 8; k++) data_b[8*k +: 8] = 8'h10 + 8'(k);
    // single requester 1, three-byte message
    add(1, 4'h0, 4'h0, 32'h0000_0000, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h2, 4'h0, 32'h0000_4100, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h2, 4'h0, 32'h0000_4100, 0,  1, 1, 4'h2, 4'h0, 1, 8'h41);
    add(0, 4'h2, 4'h0, 32'h0000_4200, 0,  1, 1, 4'h2, 4'h0, 1, 8'h42);
    add(0, 4'h2, 4'h2, 32'h0000_4300, 0,  1, 1, 4'h2, 4'h0, 1, 8'h43);
    add(0, 4'h0, 4'h0, 32'h0000_0000, 0,  0, 1, 4'h0, 4'h0, 0, 8'h00);
    // requesters 0 and 2 from reset: 0 first, one gap, then 2
    add(1, 4'h0, 4'h0, 32'h0000_0000, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h5, 4'h0, 32'h00C0_00A0, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h5, 4'h0, 32'h00C0_00A0, 0,  1, 0, 4'h1, 4'h0, 1, 8'hA0);
    add(0, 4'h5, 4'h1, 32'h00C0_00A1, 0,  1, 0, 4'h1, 4'h0, 1, 8'hA1);
    add(0, 4'h4, 4'h0, 32'h00C0_0000, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h4, 4'h0, 32'h00C0_0000, 0,  1, 2, 4'h4, 4'h0, 1, 8'hC0);
    add(0, 4'h4, 4'h4, 32'h00C1_0000, 0,  1, 2, 4'h4, 4'h0, 1, 8'hC1);
    // one-byte message from 0 leaves rr_ptr at 1, then 2 wins over 0
    add(0, 4'h1, 4'h1, 32'h0000_00B0, 0,  0, 2, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h1, 4'h1, 32'h0000_00B0, 0,  1, 0, 4'h1, 4'h0, 1, 8'hB0);
    add(0, 4'h5, 4'h0, 32'h00D0_00B1, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h5, 4'h0, 32'h00D0_00B1, 0,  1, 2, 4'h4, 4'h0, 1, 8'hD0);
    add(0, 4'h5, 4'h4, 32'h00D1_00B1, 0,  1, 2, 4'h4, 4'h0, 1, 8'hD1);
    add(0, 4'h1, 4'h0, 32'h0000_00B1, 0,  0, 2, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h1, 4'h0, 32'h0000_00B1, 0,  1, 0, 4'h1, 4'h0, 1, 8'hB1);
    add(0, 4'h1, 4'h1, 32'h0000_00B2, 0,  1, 0, 4'h1, 4'h0, 1, 8'hB2);
    // requester 3 stalled 10 cycles by fifo_full, no abort
    add(0, 4'h8, 4'h0, 32'hE000_0000, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h8, 4'h0, 32'hE000_0000, 0,  1, 3, 4'h8, 4'h0, 1, 8'hE0);
    for (int k = 0; k < 5; k++)
      add(0, 4'h8, 4'h0, 32'hE100_0000, 1,  1, 3, 4'h0, 4'h0, 0, 8'hE1);
    for (int k = 0; k < 5; k++)
      add(0, 4'h0, 4'h0, 32'hE100_0000, 1,  1, 3, 4'h0, 4'h0, 0, 8'hE1);
    add(0, 4'h8, 4'h0, 32'hE100_0000, 0,  1, 3, 4'h8, 4'h0, 1, 8'hE1);
    // requester 3 goes idle while 1 waits: abort after 4 counted idle cycles
    add(0, 4'h2, 4'h0, 32'hE200_5100, 0,  1, 3, 4'h8, 4'h0, 0, 8'hE2);
    add(0, 4'h2, 4'h0, 32'hE200_5100, 1,  1, 3, 4'h0, 4'h0, 0, 8'hE2);
    add(0, 4'h2, 4'h0, 32'hE200_5100, 0,  1, 3, 4'h8, 4'h0, 0, 8'hE2);
    add(0, 4'h2, 4'h0, 32'hE200_5100, 0,  1, 3, 4'h8, 4'h0, 0, 8'hE2);
    add(0, 4'h2, 4'h0, 32'hE200_5100, 0,  1, 3, 4'h8, 4'h8, 0, 8'hE2);
    add(0, 4'h2, 4'h0, 32'hE200_5100, 0,  0, 3, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h2, 4'h2, 32'hE200_5100, 0,  1, 1, 4'h2, 4'h0, 1, 8'h51);
    // reset mid-message, then fresh arbitration starts at index 0
    add(0, 4'h2, 4'h0, 32'h0000_5200, 0,  0, 1, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h2, 4'h0, 32'h0000_5200, 0,  1, 1, 4'h2, 4'h0, 1, 8'h52);
    add(1, 4'h2, 4'h0, 32'h0000_5300, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h9, 4'h0, 32'hF000_0060, 0,  0, 0, 4'h0, 4'h0, 0, 8'h00);
    add(0, 4'h9, 4'h0, 32'hF000_0060, 0,  1, 0, 4'h1, 4'h0, 1, 8'h60);
    foreach (vecs[n]) begin
      @(posedge clk);
      #1;
      rst = vecs[n].r;
      req_valid = vecs[n].v;
      req_last = vecs[n].l;
      req_data = vecs[n].d;
      fifo_full = vecs[n].f;
      #3;
      act = {busy, grant_id, req_ready, req_abort, fifo_write, fifo_in};
      exp = {vecs[n].b, vecs[n].g, vecs[n].ry, vecs[n].ab, vecs[n].w, vecs[n].i};
      n_vec++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d: got busy=%b gid=%0d ready=%b abort=%b wr=%b in=%h, want busy=%b gid=%0d ready=%b abort=%b wr=%b in=%h",
                 n, busy, grant_id, req_ready, req_abort, fifo_write, fifo_in,
                 vecs[n].b, vecs[n].g, vecs[n].ry, vecs[n].ab, vecs[n].w, vecs[n].i);
      end
    end
    // eight requesters, all valid with one-byte messages: grant every other cycle in order
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #3;
    for (int k = 0; k < 18; k++) begin
      logic       eb;
      logic [2:0] eg;
      eb = k[0];
      eg = 3'(eb ? k / 2 : (k == 0 ? 0 : k / 2 - 1));
      n_vec++;
      if (busy_b !== eb || gid_b !== eg || write_b !== eb || abort_b !== 8'h00 ||
          ready_b !== (eb ? 8'h01 << eg : 8'h00) || fin_b !== (eb ? 8'h10 + 8'(eg) : 8'h00)) begin
        n_bad++;
        $display("FAIL rot8 cycle %0d: got busy=%b gid=%0d wr=%b ready=%b abort=%b in=%h, want busy=%b gid=%0d wr=%b ready=%b abort=00 in=%h",
                 k, busy_b, gid_b, write_b, ready_b, abort_b, fin_b, eb, eg, eb,
                 eb ? 8'h01 << eg : 8'h00, eb ? 8'h10 + 8'(eg) : 8'h00);
      end
      @(posedge clk);
      #4;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
